// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and flag bit positions for the iterative ALU.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_SAR = 4'd8,
    OP_MUL = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction
endpackage

// File: rtl/alu_iter_seq.sv
// Iterative datapath: one shift bit or one shift-add step per cycle (start counts as the first step).
// done pulses on the final BUSY step; res/c are that step's combinational result, captured by the top.
module alu_iter_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             c
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  logic [3:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [3:0]         op_src;
  logic [WIDTH-1:0]   sh_src;
  logic [WIDTH-1:0]   sh_nxt;
  logic               shc_nxt;
  logic [2*WIDTH-1:0] acc_src;
  logic [2*WIDTH-1:0] mc_src;
  logic [WIDTH-1:0]   mpl_src;
  logic [2*WIDTH-1:0] acc_nxt;

  // Returns {bit shifted out, shifted value} for a single-bit shift.
  function automatic logic [WIDTH:0] sh_step(input logic [3:0] o, input logic [WIDTH-1:0] x);
    case (o)
      OP_SHL:  return {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      OP_SHR:  return {x[0], 1'b0, x[WIDTH-1:1]};
      default: return {x[0], x[WIDTH-1], x[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    op_src  = start ? op : op_q;
    sh_src  = start ? a : sh;
    acc_src = start ? '0 : acc;
    mc_src  = start ? {{WIDTH{1'b0}}, a} : mcand;
    mpl_src = start ? b : mplier;
    {shc_nxt, sh_nxt} = sh_step(op_src, sh_src);
    acc_nxt = acc_src + (mpl_src[0] ? mc_src : '0);
  end

  assign done = step && (cnt == CW'(1));
  assign res  = (op_q == OP_MUL) ? acc_nxt[WIDTH-1:0] : sh_nxt;
  assign c    = (op_q == OP_MUL) ? |acc_nxt[2*WIDTH-1:WIDTH] : shc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      cnt    <= '0;
      sh     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start || step) begin
      op_q   <= op_src;
      cnt    <= start ? ((op == OP_MUL) ? CW'(WIDTH - 1) : CW'(b[SHW-1:0]) - CW'(1))
                      : cnt - CW'(1);
      sh     <= sh_nxt;
      acc    <= acc_nxt;
      mcand  <= mc_src << 1;
      mplier <= mpl_src >> 1;
    end
  end
endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: 1-cycle logic/arith, max(shamt,1)-cycle shifts, WIDTH-cycle multiply.
// Single request in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_iter import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [SHW-1:0]   shamt;
  logic             iter;
  logic             accept;
  logic             seq_done;
  logic             seq_c;
  logic [WIDTH-1:0] seq_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r1;
  logic             c1;
  logic             v1;

  function automatic logic [3:0] mkflags(input logic [WIDTH-1:0] r, input logic cf, input logic vf);
    logic [3:0] f;
    f     = '0;
    f[FZ] = (r == '0);
    f[FN] = r[WIDTH-1];
    f[FC] = cf;
    f[FV] = vf;
    return f;
  endfunction

  assign shamt  = b[SHW-1:0];
  assign iter   = (is_shift(s) && (shamt > SHW'(1))) || (s == OP_MUL);
  assign accept = in_valid && in_ready;

  // Single-cycle results; shifts here only ever see amount 0 or 1.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    r1   = '0;
    c1   = 1'b0;
    v1   = 1'b0;
    case (s)
      OP_ADD: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = (a[WIDTH-1] == b[WIDTH-1]) && (r1[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r1 = diff[WIDTH-1:0];
        c1 = diff[WIDTH];
        v1 = (a[WIDTH-1] != b[WIDTH-1]) && (r1[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r1 = a & b;
      OP_OR:  r1 = a | b;
      OP_XOR: r1 = a ^ b;
      OP_NOT: r1 = ~a;
      OP_SHL: begin
        r1 = (shamt == '0) ? a : {a[WIDTH-2:0], 1'b0};
        c1 = (shamt != '0) && a[WIDTH-1];
      end
      OP_SHR: begin
        r1 = (shamt == '0) ? a : {1'b0, a[WIDTH-1:1]};
        c1 = (shamt != '0) && a[0];
      end
      OP_SAR: begin
        r1 = (shamt == '0) ? a : {a[WIDTH-1], a[WIDTH-1:1]};
        c1 = (shamt != '0) && a[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = iter ? BUSY : DONE;
      BUSY:    if (seq_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      flags <= '0;
    end else if (accept && !iter) begin
      out   <= r1;
      flags <= mkflags(r1, c1, v1);
    end else if ((state == BUSY) && seq_done) begin
      out   <= seq_res;
      flags <= mkflags(seq_res, seq_c, 1'b0);
    end
  end

  alu_iter_seq #(.WIDTH(WIDTH)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (accept && iter),
    .step  (state == BUSY),
    .op    (s),
    .a     (a),
    .b     (b),
    .done  (seq_done),
    .res   (seq_res),
    .c     (seq_c)
  );
endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter (WIDTH=8): directed vector table, handshake/reset sequences, random ops vs reference model.
module tb_alu_iter;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] s;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [3:0] flags;

  int tests = 0;
  int fails = 0;

  alu_iter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [3:0] f;
    int         lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model straight from the opcode rules, using signed/unsigned integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                       output logic [7:0] o, output logic [3:0] f, output int lat);
    int ia, ib, sa, sb, r, k;
    bit c, v;
    ia = int'(va); ib = int'(vb);
    sa = va[7] ? ia - 256 : ia;
    sb = vb[7] ? ib - 256 : ib;
    k = ib % 8;
    lat = 1; c = 0; v = 0; r = 0;
    case (op)
      4'd0: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = ia - ib; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = ia & ib;
      4'd3: r = ia | ib;
      4'd4: r = ia ^ ib;
      4'd5: r = 255 - ia;
      4'd6: begin r = ia << k; c = (k > 0) && (((ia >> (8 - k)) & 1) != 0); lat = (k > 1) ? k : 1; end
      4'd7: begin r = ia >> k; c = (k > 0) && (((ia >> (k - 1)) & 1) != 0); lat = (k > 1) ? k : 1; end
      4'd8: begin r = sa >>> k; c = (k > 0) && (((sa >>> (k - 1)) & 1) != 0); lat = (k > 1) ? k : 1; end
      4'd9: begin r = ia * ib; c = (r > 255); lat = 8; end
      default: r = 0;
    endcase
    o = r[7:0];
    f = {(o == 8'h00), o[7], c, v};
  endtask

  // Called and returns at a negedge. Issues one op, checks latency, result, hold and handshake.
  task automatic run_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] eo, input logic [3:0] ef, input int el,
                        input int hold, input string tag);
    int n;
    int busybad;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = va; b = vb; s = op;
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); s = 4'($urandom);
    n = 1;
    busybad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) busybad++;
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_ready"}, busybad, 0);
    chk({tag, " latency"}, out_valid ? n : -1, el);
    chk({tag, " out"}, {24'b0, out}, {24'b0, eo});
    chk({tag, " flags"}, {28'b0, flags}, {28'b0, ef});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, {18'b0, out_valid, in_ready, flags, out}, {18'b0, 1'b1, 1'b0, ef, eo});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " post_handshake"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin : main
    logic [3:0] rs;
    logic [7:0] ra, rb, mo;
    logic [3:0] mf;
    int ml;
    int bad;

    tbl[0]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1};
    tbl[1]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1};
    tbl[2]  = '{4'd1, 8'h00, 8'h01, 8'hFF, 4'b0110, 1};
    tbl[3]  = '{4'd6, 8'h81, 8'h03, 8'h08, 4'b0000, 3};
    tbl[4]  = '{4'd8, 8'h80, 8'h00, 8'h80, 4'b0100, 1};
    tbl[5]  = '{4'd9, 8'h0F, 8'h11, 8'hFF, 4'b0100, 8};
    tbl[6]  = '{4'd9, 8'h10, 8'h10, 8'h00, 4'b1010, 8};
    tbl[7]  = '{4'd7, 8'h81, 8'h01, 8'h40, 4'b0010, 1};
    tbl[8]  = '{4'd8, 8'h90, 8'h07, 8'hFF, 4'b0100, 7};
    tbl[9]  = '{4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1};
    tbl[10] = '{4'd4, 8'hA5, 8'hA5, 8'h00, 4'b1000, 1};
    tbl[11] = '{4'hA, 8'h12, 8'h34, 8'h00, 4'b1000, 1};
    tbl[12] = '{4'd6, 8'h01, 8'h02, 8'h04, 4'b0000, 2};
    tbl[13] = '{4'd6, 8'h81, 8'h01, 8'h02, 4'b0010, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; s = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {18'b0, out_valid, in_ready, flags, out}, {18'b0, 1'b0, 1'b1, 4'b0, 8'b0});

    for (int i = 0; i < 14; i++)
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].f, tbl[i].lat, 0, $sformatf("vec%0d", i));

    // Result held for 5 cycles without out_ready, then a reserved op right after the handshake.
    run_op(4'd0, 8'h03, 8'h04, 8'h07, 4'b0000, 1, 5, "hold5");
    run_op(4'hF, 8'h55, 8'hAA, 8'h00, 4'b1000, 1, 0, "rsv_after_hs");
    run_op(4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 0, "and_nonzero");

    // Reset at BUSY step 3 of a multiply.
    in_valid = 1'b1; s = 4'd9; a = 8'h0F; b = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mul_abort_state", {18'b0, out_valid, in_ready, flags, out}, {18'b0, 1'b0, 1'b1, 4'b0, 8'b0});
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("mul_abort_no_result", bad, 0);
    run_op(4'd0, 8'h02, 8'h03, 8'h05, 4'b0000, 1, 0, "add_after_abort");

    // Reset in DONE wins over a simultaneous handshake.
    in_valid = 1'b1; s = 4'd0; a = 8'h10; b = 8'h20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("done_before_rst", {23'b0, out_valid, out}, {23'b0, 1'b1, 8'h30});
    out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    chk("done_abort_state", {18'b0, out_valid, in_ready, flags, out}, {18'b0, 1'b0, 1'b1, 4'b0, 8'b0});

    for (int i = 0; i < 300; i++) begin
      rs = (i % 17 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(rs, ra, rb, mo, mf, ml);
      run_op(rs, ra, rb, mo, mf, ml, $urandom_range(0, 2), $sformatf("rnd%0d s=%0d a=%0h b=%0h", i, rs, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
